// File: rtl/burst_line_master.sv
// rtl/burst_line_master.sv - single-line Avalon-style burst master with local line buffer
module burst_line_master #(
  parameter  int LINE_WORDS = 8,
  parameter  int TIMEOUT    = 255,
  localparam int IW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int CW         = $clog2(LINE_WORDS) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [29:0]   cmd_addr_i,
  input  logic [3:0]    cmd_byteenable_i,
  input  logic          buf_we_i,
  input  logic [IW-1:0] buf_idx_i,
  input  logic [31:0]   buf_wdata_i,
  output logic [31:0]   buf_rdata_o,
  output logic          done_o,
  output logic          err_o,
  output logic [29:0]   bus_address,
  output logic [4:0]    bus_burstcount,
  output logic [3:0]    bus_byteenable,
  output logic          bus_read,
  output logic          bus_write,
  output logic [31:0]   bus_writedata,
  input  logic          m_waitrequest,
  input  logic          m_readdatavalid,
  input  logic          m_writeresponsevalid,
  input  logic [31:0]   m_readdata,
  input  logic [1:0]    m_response
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  localparam logic [29:0] ALIGN_MASK = ~30'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

  state_t         state_q, state_d;
  logic           wr_q;
  logic [29:0]    addr_q;
  logic [3:0]     be_q;
  logic [CW-1:0]  beat_cnt;
  logic           err_q;
  logic [7:0]     timer_q;
  logic [31:0]    buffer [LINE_WORDS];

  logic           active, accept, beat, last_beat, expire, cmd_fire;
  logic [IW-1:0]  beat_idx;

  assign active    = (state_q == REQ) || (state_q == DATA);
  assign accept    = (state_q == REQ) && !m_waitrequest;
  assign beat      = active && (wr_q ? m_writeresponsevalid : m_readdatavalid);
  assign last_beat = beat && (beat_cnt == LAST_CNT);
  // Any bus progress (acceptance or a beat) defers the timeout, so a final beat always wins.
  assign expire    = active && !accept && !beat && (timer_q == 8'(TIMEOUT));
  assign cmd_fire  = (state_q == IDLE) && cmd_valid_i;
  assign beat_idx  = beat_cnt[IW-1:0];

  assign buf_rdata_o = buffer[buf_idx_i];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and all state-decoded outputs
  always_comb begin
    state_d        = state_q;
    cmd_ready_o    = 1'b0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    bus_address    = '0;
    bus_burstcount = '0;
    bus_byteenable = '0;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_writedata  = '0;
    if (active && wr_q) bus_writedata = buffer[beat_idx];
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = REQ;
      end
      REQ: begin
        bus_read       = !wr_q;
        bus_write      = wr_q;
        bus_address    = addr_q;
        bus_byteenable = be_q;
        bus_burstcount = 5'(LINE_WORDS);
        if (last_beat || expire) state_d = DONE;
        else if (accept)         state_d = DATA;
      end
      DATA: begin
        if (last_beat || expire) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, beat counter, sticky error and progress timer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else if (cmd_fire) begin
      wr_q     <= cmd_write_i;
      addr_q   <= cmd_addr_i & ALIGN_MASK;
      be_q     <= cmd_byteenable_i;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else if (active) begin
      if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (m_response != 2'b00) err_q <= 1'b1;
      end
      if (accept || beat) timer_q <= '0;
      else if (expire)    err_q   <= 1'b1;
      else                timer_q <= timer_q + 8'd1;
    end
  end

  // Line buffer: client writes while idle, read-burst capture while active; never reset
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && buf_we_i) buffer[buf_idx_i] <= buf_wdata_i;
    else if (beat && !wr_q)          buffer[beat_idx]  <= m_readdata;
  end

endmodule
